imm_ext_pipe: RTL



---
 rtl/imm_ext_pkg.sv | 17 +
 rtl/imm_ext_if.sv | 41 ++++
 rtl/imm_ext_slice.sv | 48 ++++
 rtl/imm_ext_pipe.sv | 98 +++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared encodings and default widths for the immediate extender.
// Mode codes 5-7 are illegal (flagged only when IMM_EXT_CHECK_EN is defined).
package imm_ext_pkg;

    localparam int MODE_W    = 3;
    localparam int IN_W_DEF  = 16;
    localparam int OUT_W_DEF = 32;

    typedef enum logic [MODE_W-1:0] {
        IMM_SEXT   = 3'd0,
        IMM_ZEXT   = 3'd1,
        IMM_UPPER  = 3'd2,
        IMM_BRANCH = 3'd3,
        IMM_PASS   = 3'd4
    } imm_mode_e;

endpackage

// File: rtl/imm_ext_if.sv
// Valid/ready bundle between the decode side, the extender and its consumer.
// out_err exists only when IMM_EXT_CHECK_EN is defined.
interface imm_ext_if
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_imm;
    logic [MODE_W-1:0] in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
`ifdef IMM_EXT_CHECK_EN
    logic              out_err;

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
`else
    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
`endif

endinterface

// File: rtl/imm_ext_slice.sv
// One elastic register slice: loads when empty or drained this cycle.
// Flush clears the valid bit and wins over a load; data is left as is.
module imm_ext_slice #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         up_valid_i,
    output logic         up_ready_o,
    input  logic [W-1:0] up_data_i,
    output logic         dn_valid_o,
    input  logic         dn_ready_i,
    output logic [W-1:0] dn_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    assign load = !valid_q || dn_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = up_valid_i;
            if (up_valid_i) data_d = up_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign up_ready_o = load;
    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: combinational extend, then STAGES slices.
// IMM_EXT_CHECK_EN: modes 5-7 yield zero data and raise out_err.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int STAGES = 1
) (
    input logic      clk,
    input logic      rst_n,
    input logic      flush,
    imm_ext_if.slave bus
);

    localparam int PAD = OUT_W - IN_W;
`ifdef IMM_EXT_CHECK_EN
    localparam int PW = OUT_W + 1;
`else
    localparam int PW = OUT_W;
`endif

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;
    logic [PW-1:0]    pay0;
`ifdef IMM_EXT_CHECK_EN
    logic             err;
`endif

    always_comb begin
        sext = {{PAD{bus.in_imm[IN_W-1]}}, bus.in_imm};
        ext  = sext;
`ifdef IMM_EXT_CHECK_EN
        err  = 1'b0;
`endif
        case (bus.in_mode)
            IMM_SEXT:   ext = sext;
            IMM_ZEXT:   ext = {{PAD{1'b0}}, bus.in_imm};
            IMM_UPPER:  ext = {bus.in_imm, {PAD{1'b0}}};
            IMM_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
            IMM_PASS:   ext = {{PAD{1'b0}}, bus.in_imm};
            default: begin
`ifdef IMM_EXT_CHECK_EN
                ext = '0;
                err = 1'b1;
`else
                ext = sext;
`endif
            end
        endcase
    end

`ifdef IMM_EXT_CHECK_EN
    assign pay0 = {err, ext};
`else
    assign pay0 = ext;
`endif

    // Per-stage nets live in their own scope so the ready chain is not one vector.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic          up_v, up_r, dn_v, dn_r;
        logic [PW-1:0] up_d, dn_d;

        if (k == 0) begin : g_head
            assign up_v = bus.in_valid;
            assign up_d = pay0;
        end else begin : g_body
            assign up_v = g_stg[k-1].dn_v;
            assign up_d = g_stg[k-1].dn_d;
        end

        if (k == STAGES - 1) begin : g_tail
            assign dn_r = bus.out_ready;
        end else begin : g_mid
            assign dn_r = g_stg[k+1].up_r;
        end

        imm_ext_slice #(.W(PW)) u_slice (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .up_valid_i (up_v),
            .up_ready_o (up_r),
            .up_data_i  (up_d),
            .dn_valid_o (dn_v),
            .dn_ready_i (dn_r),
            .dn_data_o  (dn_d)
        );
    end

    assign bus.in_ready  = g_stg[0].up_r;
    assign bus.out_valid = g_stg[STAGES-1].dn_v;
    assign bus.out_data  = g_stg[STAGES-1].dn_d[OUT_W-1:0];
`ifdef IMM_EXT_CHECK_EN
    assign bus.out_err   = g_stg[STAGES-1].dn_d[OUT_W];
`endif

endmodule
